// File: rtl/jtframe_rom_pkg.sv
// Shared types and default widths for the ROM arbiter and its per-slot cache.
package jtframe_rom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam int AW_DEF = 22;
    localparam int DW_DEF = 16;

endpackage

// File: rtl/jtframe_rom_slot.sv
// One-word read cache for a single requester: stores the last fetched address/data
// and reports a registered hit while the requester keeps asking for that address.
module jtframe_rom_slot
    import jtframe_rom_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          clr,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    output logic          hit,
    output logic          ok,
    output logic [DW-1:0] dout
);

    logic [AW-1:0] cache_addr;
    logic          valid;
    logic          fill_hit;

    assign hit      = cs & valid & (addr == cache_addr);
    // A fill for the address still being asked for raises ok in the same edge
    // that loads the cache, so ok follows data_rdy by one clock.
    assign fill_hit = cs & fill & (addr == fill_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_addr <= '0;
            dout       <= '0;
            valid      <= 1'b0;
            ok         <= 1'b0;
        end else begin
            ok <= ~clr & (hit | fill_hit);
            if (clr) begin
                valid <= 1'b0;
            end else if (fill) begin
                valid      <= 1'b1;
                cache_addr <= fill_addr;
                dout       <= fill_data;
            end
        end
    end

endmodule

// File: rtl/jtframe_rom_arb.sv
// Read-only SDRAM arbiter: round-robin grants of one controller read port among
// SLOTS cached requesters, paused while a ROM download is running.
module jtframe_rom_arb
    import jtframe_rom_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read
);

    localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    arb_state_t    state, state_nxt;
    logic [GW-1:0] gnt, rr, sel;
    logic [SLOTS-1:0] hit, pending;
    logic          any_pend, load, fill_en;
    int            j;

    assign fill_en = (state == WAIT) & data_rdy & ~downloading;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        jtframe_rom_slot #(.AW(AW), .DW(DW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .cs        (slot_cs[i]),
            .addr      (slot_addr[i*AW +: AW]),
            .clr       (downloading),
            .fill      (fill_en & (gnt == GW'(i))),
            .fill_addr (sdram_addr),
            .fill_data (data_read),
            .hit       (hit[i]),
            .ok        (slot_ok[i]),
            .dout      (slot_dout[i*DW +: DW])
        );
        assign pending[i] = slot_cs[i] & ~hit[i] & ~((state != IDLE) & (gnt == GW'(i)));
    end

    // Scan rr+1 .. rr+SLOTS with explicit wrap so non-power-of-two SLOTS works;
    // walking downwards lets the nearest pending slot win.
    always_comb begin
        sel      = rr;
        any_pend = 1'b0;
        j        = 0;
        for (int k = SLOTS; k >= 1; k--) begin
            j = int'(rr) + k;
            if (j >= SLOTS) j = j - SLOTS;
            if (pending[j]) begin
                sel      = GW'(j);
                any_pend = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: if (!downloading && any_pend) begin
                state_nxt = REQ;
                load      = 1'b1;
            end
            REQ:  if (sdram_ack) state_nxt = WAIT;
            WAIT: if (data_rdy)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            rr         <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                gnt        <= sel;
                sdram_addr <= slot_addr[sel*AW +: AW];
                sdram_req  <= 1'b1;
            end else if (state == REQ && sdram_ack) begin
                sdram_req <= 1'b0;
            end
            if (state == WAIT && data_rdy) rr <= gnt;
        end
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed bench for jtframe_rom_arb: table of cache-hit vectors plus scripted
// controller sequences for misses, round robin, in-flight changes, download and reset.
module tb_jtframe_rom_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                downloading;
    logic [SLOTS-1:0]    slot_cs;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*DW-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [DW-1:0]       data_read;

    int checks = 0;
    int errors = 0;
    int req_edges = 0;
    logic req_prev = 1'b0;

    logic [AW-1:0] exp_q[$];

    typedef struct {
        logic [3:0]  cs;
        logic [21:0] addr0;
        logic        dl;
        logic [3:0]  exp_ok;
        logic        exp_req;
        logic [15:0] exp_dout0;
    } vec_t;
    vec_t vecs[8];

    jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sdram_req && !req_prev) req_edges++;
        req_prev = sdram_req;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dout_of(input int i);
        return slot_dout[i*DW +: DW];
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    // driver tasks: all start and end on a falling edge
    task automatic wait_req(input string name, output logic [AW-1:0] addr_seen);
        bit got = 0;
        addr_seen = '0;
        for (int i = 0; i < 40; i++) begin
            if (sdram_req) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: sdram_req got 0 expected 1 within 40 cycles", name);
        end
        addr_seen = sdram_addr;
    endtask

    task automatic do_ack(input int dly);
        repeat (dly) @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
    endtask

    task automatic do_rdy(input int dly, input logic [DW-1:0] d);
        repeat (dly - 1) @(negedge clk);
        data_rdy  = 1'b1;
        data_read = d;
        @(negedge clk);
        data_rdy  = 1'b0;
        data_read = '0;
    endtask

    task automatic serve(input string name, input logic [DW-1:0] d);
        logic [AW-1:0] a, e;
        wait_req(name, a);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check(name, 64'(a), 64'(e));
        do_ack(2);
        do_rdy(3, d);
    endtask

    initial begin
        logic [AW-1:0] a;
        int base;

        vecs[0] = '{4'b0001, 22'h00100, 1'b0, 4'b0001, 1'b0, 16'hA55A};
        vecs[1] = '{4'b0000, 22'h00100, 1'b0, 4'b0000, 1'b0, 16'hA55A};
        vecs[2] = '{4'b0001, 22'h00100, 1'b0, 4'b0001, 1'b0, 16'hA55A};
        vecs[3] = '{4'b0000, 22'h00123, 1'b0, 4'b0000, 1'b0, 16'hA55A};
        vecs[4] = '{4'b0001, 22'h00100, 1'b0, 4'b0001, 1'b0, 16'hA55A};
        vecs[5] = '{4'b0001, 22'h00100, 1'b1, 4'b0000, 1'b0, 16'hA55A};
        vecs[6] = '{4'b0001, 22'h00100, 1'b1, 4'b0000, 1'b0, 16'hA55A};
        vecs[7] = '{4'b0000, 22'h00100, 1'b0, 4'b0000, 1'b0, 16'hA55A};

        rst_n = 1'b0; downloading = 1'b0; slot_cs = '0; slot_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        repeat (3) @(negedge clk);
        check("reset slot_ok", 64'(slot_ok), 64'h0);
        check("reset slot_dout", 64'(slot_dout), 64'h0);
        check("reset sdram_req", 64'(sdram_req), 64'h0);
        check("reset sdram_addr", 64'(sdram_addr), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle sdram_req", 64'(sdram_req), 64'h0);

        // single miss
        set_addr(0, 22'h00100);
        slot_cs = 4'b0001;
        @(negedge clk);
        wait_req("miss req", a);
        check("miss sdram_addr", 64'(a), 64'h00100);
        do_ack(2);
        check("miss req low after ack", 64'(sdram_req), 64'h0);
        do_rdy(5, 16'hA55A);
        check("miss slot_ok", 64'(slot_ok), 64'h1);
        check("miss slot_dout0", 64'(dout_of(0)), 64'hA55A);

        // table: cache hits, drops and download clearing
        base = req_edges;
        for (int v = 0; v < 8; v++) begin
            slot_cs = vecs[v].cs;
            set_addr(0, vecs[v].addr0);
            downloading = vecs[v].dl;
            @(negedge clk);
            check($sformatf("vec%0d slot_ok", v), 64'(slot_ok), 64'(vecs[v].exp_ok));
            check($sformatf("vec%0d sdram_req", v), 64'(sdram_req), 64'(vecs[v].exp_req));
            check($sformatf("vec%0d slot_dout0", v), 64'(dout_of(0)), 64'(vecs[v].exp_dout0));
        end
        check("hit table req count", 64'(req_edges - base), 64'h0);

        // round robin from rr=0: order 1,2,3,0
        for (int i = 0; i < SLOTS; i++) set_addr(i, 22'h00200 + AW'(i));
        exp_q.push_back(22'h00201); exp_q.push_back(22'h00202);
        exp_q.push_back(22'h00203); exp_q.push_back(22'h00200);
        base = req_edges;
        slot_cs = 4'b1111;
        @(negedge clk);
        serve("rr grant 1", 16'hC0D1);
        serve("rr grant 2", 16'hC0D2);
        serve("rr grant 3", 16'hC0D3);
        serve("rr grant 0", 16'hC0D0);
        repeat (4) @(negedge clk);
        check("rr req count", 64'(req_edges - base), 64'h4);
        check("rr slot_ok", 64'(slot_ok), 64'hF);
        for (int i = 0; i < SLOTS; i++)
            check($sformatf("rr slot_dout%0d", i), 64'(dout_of(i)), 64'(16'hC0D0 + 16'(i)));

        // address change while slot 2 is in flight
        slot_cs = 4'b0100;
        set_addr(2, 22'h00010);
        @(negedge clk);
        wait_req("chg first req", a);
        check("chg first addr", 64'(a), 64'h00010);
        do_ack(2);
        set_addr(2, 22'h00020);
        do_rdy(3, 16'hBEEF);
        check("chg stale fill slot_ok", 64'(slot_ok), 64'h0);
        wait_req("chg second req", a);
        check("chg second addr", 64'(a), 64'h00020);
        do_ack(2);
        do_rdy(3, 16'h2222);
        check("chg slot_ok2", 64'(slot_ok), 64'h4);
        check("chg slot_dout2", 64'(dout_of(2)), 64'h2222);

        // download starting during WAIT
        slot_cs = 4'b1000;
        set_addr(3, 22'h00300);
        @(negedge clk);
        wait_req("dl req", a);
        check("dl addr", 64'(a), 64'h00300);
        do_ack(2);
        downloading = 1'b1;
        do_rdy(3, 16'h3333);
        check("dl slot_ok", 64'(slot_ok), 64'h0);
        check("dl dout3 kept", 64'(dout_of(3)), 64'hC0D3);
        base = req_edges;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("dl no req %0d", i), 64'(sdram_req), 64'h0);
        end
        check("dl req count", 64'(req_edges - base), 64'h0);
        downloading = 1'b0;
        @(negedge clk);
        wait_req("post dl req", a);
        check("post dl addr", 64'(a), 64'h00300);
        do_ack(2);
        do_rdy(3, 16'h3333);
        check("post dl slot_ok", 64'(slot_ok), 64'h8);
        check("post dl slot_dout3", 64'(dout_of(3)), 64'h3333);

        // asynchronous reset while in REQ
        set_addr(1, 22'h00400);
        slot_cs = 4'b1010;
        @(negedge clk);
        wait_req("rst req", a);
        check("rst pre slot_ok", 64'(slot_ok), 64'h8);
        rst_n = 1'b0;
        #1;
        check("rst async sdram_req", 64'(sdram_req), 64'h0);
        check("rst async slot_ok", 64'(slot_ok), 64'h0);
        check("rst async sdram_addr", 64'(sdram_addr), 64'h0);
        check("rst async slot_dout", 64'(slot_dout), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(22'h00400);
        exp_q.push_back(22'h00300);
        serve("after rst grant 1", 16'h4444);
        serve("after rst grant 3", 16'h5555);
        check("after rst slot_ok", 64'(slot_ok), 64'hA);
        check("after rst slot_dout1", 64'(dout_of(1)), 64'h4444);
        check("after rst slot_dout3", 64'(dout_of(3)), 64'h5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
